// File: rtl/bcd_display_pkg.sv
// ---------------------------------------------------------------------------
// bcd_display_pkg
// Shared constants and types for the BCD seven-segment display slice.
//   DIGIT_W      : width of one BCD nibble
//   SEG_DASH     : pattern shown for a nibble above 9 (segment g only)
//   SEG_BLANK    : all segments off
//   SEG_LUT      : gfedcba patterns for the decimal digits 0..9
//   scan_state_t : IDLE until the first capture, then SHOW forever
//   nibble_invalid() : true for a nibble that is not a decimal digit
// ---------------------------------------------------------------------------
package bcd_display_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [6:0] SEG_LUT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   typedef enum logic {
      IDLE,
      SHOW
   } scan_state_t;

   // Anything from A to F cannot come out of a healthy converter.
   function automatic logic nibble_invalid(input logic [DIGIT_W-1:0] nibble);
      return nibble > DIGIT_W'(9);
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// Combinational decoder from one BCD nibble to a seven-segment pattern.
// Ports:
//   nibble : input  [DIGIT_W-1:0]  BCD digit to show
//   seg    : output [6:0]          {g,f,e,d,c,b,a}, active-high; a dash for
//                                  values above 9
// ---------------------------------------------------------------------------
module bcd_to_seg
   import bcd_display_pkg::*;
(
   input  logic [DIGIT_W-1:0] nibble,
   output logic [6:0]         seg
);

   // Start from the dash so the six non-decimal codes need no entries of
   // their own; the loop keeps every table index a constant.
   always_comb begin
      seg = SEG_DASH;
      for (int i = 0; i < 10; i++) begin
         if (nibble == DIGIT_W'(i)) begin
            seg = SEG_LUT[i];
         end
      end
   end

endmodule

// File: rtl/bcd_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// bcd_seven_seg_scanner
// Captures the packed BCD vector from the binary-to-BCD converter whenever
// its done strobe is high and time-multiplexes the digits onto a single
// seven-segment display, one digit per scanDivider clocks.
// Parameters:
//   numberOfDigits : digits captured and scanned (>= 1)
//   scanDivider    : clocks per digit slot (>= 2)
// Ports:
//   clk           : input               system clock
//   rst           : input               asynchronous reset, active-high
//   BinaryDecimal : input  [N-1:0][3:0] BCD digits, digit 0 least significant
//   to2_10Sum     : input               converter done strobe, captures data
//   seg           : output [6:0]        {g,f,e,d,c,b,a}, active-high, registered
//   an            : output [N-1:0]      one-hot digit enable, registered
//   bcdErr        : output              captured value holds a nibble above 9
// Build option:
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits above digit 0
//                           are blanked while the anode scan continues.
// ---------------------------------------------------------------------------
module bcd_seven_seg_scanner
   import bcd_display_pkg::*;
#(
   parameter int numberOfDigits = 3,
   parameter int scanDivider    = 50000
)
(
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [numberOfDigits-1:0][DIGIT_W-1:0]  BinaryDecimal,
   input  logic                                    to2_10Sum,
   output logic [6:0]                              seg,
   output logic [numberOfDigits-1:0]               an,
   output logic                                    bcdErr
);

   localparam int PRESC_W = (scanDivider > 1) ? $clog2(scanDivider) : 1;
   localparam int IDX_W   = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(scanDivider - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(numberOfDigits - 1);

   scan_state_t                               state;
   logic [numberOfDigits-1:0][DIGIT_W-1:0]    capture_q;
   logic [PRESC_W-1:0]                        presc_q;
   logic [IDX_W-1:0]                          idx_q;

   logic                                      capture_err;
   logic [DIGIT_W-1:0]                        digit_sel;
   logic [6:0]                                seg_decoded;
   logic [6:0]                                seg_next;
   logic [numberOfDigits-1:0]                 an_next;

   // The error flag is computed from the incoming vector so it can be
   // registered on the very edge that captures it.
   always_comb begin
      capture_err = 1'b0;
      for (int i = 0; i < numberOfDigits; i++) begin
         if (nibble_invalid(BinaryDecimal[i])) begin
            capture_err = 1'b1;
         end
      end
   end

   // Digit mux and anode decode, both driven by the current scan index.
   // The index never leaves 0..numberOfDigits-1, so the zero default of the
   // mux is never actually shown.
   always_comb begin
      digit_sel = '0;
      an_next   = '0;
      for (int i = 0; i < numberOfDigits; i++) begin
         if (idx_q == IDX_W'(i)) begin
            digit_sel  = capture_q[i];
            an_next[i] = 1'b1;
         end
      end
   end

   bcd_to_seg u_bcd_to_seg (
      .nibble (digit_sel),
      .seg    (seg_decoded)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [numberOfDigits-1:0] leading_zero;
   logic                      upper_zero;
   logic                      blank_digit;

   // leading_zero[i] is set when digit i and every digit above it are zero.
   // Invalid nibbles are non-zero, so they stop the blanking run. Digit 0
   // is left out of the selection so a lone zero is still visible.
   always_comb begin
      upper_zero   = 1'b1;
      leading_zero = '0;
      for (int i = numberOfDigits - 1; i >= 0; i--) begin
         upper_zero      = upper_zero & (capture_q[i] == '0);
         leading_zero[i] = upper_zero;
      end
      blank_digit = 1'b0;
      for (int i = 1; i < numberOfDigits; i++) begin
         if (idx_q == IDX_W'(i)) begin
            blank_digit = leading_zero[i];
         end
      end
      seg_next = blank_digit ? SEG_BLANK : seg_decoded;
   end
`else
   // Every digit is shown, leading zeros included.
   always_comb begin
      seg_next = seg_decoded;
   end
`endif

   // Scan controller. The outputs are registered from the state, index and
   // capture register as they stood before this edge, which gives one clock
   // of latency from a capture to the first digit appearing. A capture
   // outranks a prescaler wrap on the same edge, so the slot timing always
   // restarts cleanly on digit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         capture_q <= '0;
         presc_q   <= '0;
         idx_q     <= '0;
         seg       <= SEG_BLANK;
         an        <= '0;
         bcdErr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               seg <= SEG_BLANK;
               an  <= '0;
            end
            SHOW: begin
               seg <= seg_next;
               an  <= an_next;
            end
            default: begin
               seg <= SEG_BLANK;
               an  <= '0;
            end
         endcase

         if (to2_10Sum) begin
            capture_q <= BinaryDecimal;
            presc_q   <= '0;
            idx_q     <= '0;
            bcdErr    <= capture_err;
            state     <= SHOW;
         end else if (state == SHOW) begin
            if (presc_q == PRESC_LAST) begin
               presc_q <= '0;
               idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
               presc_q <= presc_q + PRESC_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/bcd_seven_seg_scanner.md
Name: bcd_seven_seg_scanner

Overview:
Downstream consumer of the binary-to-BCD converter. It captures the packed BCD digit vector when the converter's done strobe is high, then drives a time-multiplexed common-anode/cathode-agnostic 7-segment display. It scans one digit per scan tick. It also flags non-decimal nibbles. The block sits between the converter and the board display pins.

Parameters:
numberOfDigits, 3, number of BCD digits captured and scanned; must match the converter and be at least 1.
scanDivider, 50000, clock cycles per digit slot; must be at least 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
BinaryDecimal  input  [numberOfDigits-1:0][3:0]  packed BCD digits from the converter; digit 0 is the least significant
to2_10Sum  input  1  converter done/valid strobe; BinaryDecimal is captured on any clk edge where this is high
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered
an  output  numberOfDigits  one-hot digit enable, active-high, registered
bcdErr  output  1  high while the captured value contains a nibble greater than 9, registered

Behaviour:
- Reset (asynchronous, rst=1): seg=0, an=0, bcdErr=0, the capture register is 0, the prescaler is 0, the digit index is 0, and the state is IDLE. Reset asserted mid-scan aborts immediately. No capture occurs while rst is high.
- States:
  - IDLE: no data since reset; an=0, seg=0.
  - SHOW: scanning.
  - Transitions: IDLE->SHOW on the first capture. SHOW persists until reset.
- Capture: on a clk edge with to2_10Sum=1:
  - the capture register loads BinaryDecimal;
  - the prescaler resets to 0 and the digit index resets to 0;
  - bcdErr updates to the OR over all digits of (nibble > 9).
  A held strobe recaptures every cycle, and the scan stays frozen on digit 0 until the strobe drops.
- Prescaler:
  - In SHOW it counts 0..scanDivider-1.
  - At terminal count it wraps to 0 and advances the index: the index wraps numberOfDigits-1 -> 0.
  - Width is $clog2(scanDivider).
- Simultaneous capture and terminal count: the capture wins, so the index goes to 0 and the prescaler to 0.
- Outputs are registered from the current state, index and capture register, giving one clk of latency.
  - an = one-hot(index).
  - seg = decode(capture[index]).
  - Example: a capture at edge N shows digit 0 on seg/an after edge N+1.
- Decode, segments gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles A-F produce a dash, 40 (segment g only).
- Each digit slot lasts exactly scanDivider cycles. A full refresh takes numberOfDigits*scanDivider cycles.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: when scanning digit i, seg=0 (blank) if every digit from numberOfDigits-1 down to i is 0 and i>0. Digit 0 is never blanked. an still scans normally. Invalid nibbles count as non-zero.
- Undefined: all digits are displayed, including leading zeros.

Decomposition:
- Package bcd_display_pkg holds:
  - constant DIGIT_W=4;
  - the segment constants SEG_DASH=7'h40 and SEG_BLANK=7'h00;
  - the 10-entry segment lookup constant array;
  - typedef enum logic {IDLE, SHOW} scan_state_t.
- One combinational sub-module, bcd_to_seg: a 4-bit nibble in, 7-bit segment pattern out, with the dash for values above 9. It is instantiated once on the muxed digit.

Test Plan (numberOfDigits=3, scanDivider=4):
- Reset, then no strobe for 50 cycles -> an=000, seg=00, bcdErr=0 throughout.
- Capture {0,1,1} (binary 11, 1-cycle strobe) -> one cycle later an=001, seg=06. After 4 cycles an=010, seg=06. After 4 more an=100, seg=3F. It then wraps to an=001.
- Capture {9,8,7} -> the slots show 07, 7F, 6F in order, bcdErr=0. Then capture {0xA,0,5} -> bcdErr=1 and digit 2 shows 40. Then capture {1,2,3} -> bcdErr=0.
- Strobe issued on the exact cycle the prescaler hits 3 while index=1 -> the next output is an=001 with the new digit-0 pattern, and the prescaler restarts at 0.
- rst pulsed mid-slot while index=2 -> an=000 and seg=00 immediately, without waiting for a clock. The block stays IDLE until the next strobe.
- With LEADING_ZERO_BLANK_EN, capture {0,0,0} -> the digit-2 and digit-1 slots show seg=00 and the digit-0 slot shows 3F. Capture {0,1,1} -> the digit-2 slot shows seg=00 and digit 1 shows 06.
